imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
Boot-time loader that sits upstream of the RISC-8 instruction memory. It receives a program image over UART (8N1) and writes it word by word into IMEM port A. It holds the pipeline core in reset until a complete image with a valid checksum has been written. After a successful load it releases the core; a new sync byte at any time restarts loading and re-asserts core reset.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate
ADDR_W, 10, IMEM word-address width
MAX_WORDS, 1024, largest accepted image length in words
CLKS_PER_BIT, CLK_HZ/BAUD (integer divide), clocks per UART bit; overridable for simulation

Ports:
clk  in  1  system clock
reset_n_in  in  1  asynchronous active-low reset
uart_rx  in  1  asynchronous serial input, idle high
imem_we  out  1  one-cycle write strobe to IMEM
imem_addr  out  ADDR_W  IMEM word address
imem_din  out  16  IMEM write data
core_reset_n  out  1  active-low reset to the pipeline core
load_done  out  1  high while a valid image is loaded
load_error  out  1  sticky error flag for the last load attempt

Behaviour:
- Reset: clk is the clock; reset_n_in is asynchronous and active-low. During reset, all outputs are 0. This includes core_reset_n, so the core is held in reset. FSM goes to IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer; the start bit is re-checked at CLKS_PER_BIT/2. If it is high, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - The stop bit is sampled at mid-bit. Stop=0 means framing error.
  - The receiver produces a one-cycle byte_valid plus byte and frame_err.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO, then 2*LEN data bytes (high byte first per word), then CHK.
  - CHK is the XOR of all data bytes only.
- FSM states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHECK, RUN, ERROR.
  - IDLE: byte 0xA5 goes to LEN_H. Any other byte is ignored.
  - LEN_H / LEN_L: capture 16-bit LEN.
    - If LEN is 0 or LEN > MAX_WORDS, go to ERROR.
    - Otherwise clear the word counter and checksum, then go to DATA_H.
  - DATA_H: latch the high byte, then go to DATA_L.
  - DATA_L, on byte received:
    - Next cycle: imem_we=1 for exactly one cycle, imem_addr=word counter, imem_din={hi,lo}.
    - Word counter increments after the write.
    - When the counter reaches LEN, go to CHECK; otherwise go to DATA_H.
  - CHECK, on byte received:
    - Match: go to RUN, core_reset_n=1, load_done=1, load_error=0.
    - Mismatch: go to ERROR.
  - RUN / ERROR: byte 0xA5 starts a new load.
    - Same cycle: core_reset_n=0, load_done=0. load_error is kept until the new load resolves.
    - Next state is LEN_H. Other bytes are ignored.
  - ERROR: load_error=1, core_reset_n=0.
  - Any frame_err in states LEN_H..CHECK: go to ERROR. In IDLE/RUN, frame_err is ignored.
- Outside RUN, core_reset_n is 0 in every state.
- In RUN, 0xA5 bytes are consumed by the loader. The loader does not discriminate application traffic.
- imem_addr/imem_din hold their last value when imem_we=0.
- Word counter is ADDR_W+1 bits, so LEN=MAX_WORDS is reached without wrap.
- An image shorter than MAX_WORDS leaves the remaining IMEM contents unchanged.
- Reset mid-load: the load is abandoned immediately. IDLE is entered, core stays in reset, and no partial write strobe occurs.

Decomposition:
- Shared package holds:
  - SYNC_BYTE=8'hA5
  - the FSM state enum (3-bit)
  - the default CLKS_PER_BIT computation function
- One natural sub-module: uart_rx_8n1. It contains the synchronizer, bit timer, shift register and frame_err. Its outputs are byte_valid, byte, frame_err.
- The loader FSM, counter, checksum and IMEM drive live in imem_uart_loader.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Load A5 00 02 12 34 AB CD CHK=0x40 -> two imem_we pulses: addr0=0x1234, addr1=0xABCD; then core_reset_n=1, load_done=1, load_error=0.
2. Same frame with CHK=0x41 -> both words are written, then ERROR: load_error=1, core_reset_n stays 0, load_done=0.
3. A5 00 00 -> ERROR immediately, no imem_we. A5 04 01 (LEN=1025) -> ERROR, no imem_we.
4. Garbage bytes 0x00, 0xFF, 0x5A before A5 and a valid 1-word frame -> garbage ignored, single write, RUN reached. A 4-clock low glitch on uart_rx causes no byte.
5. After RUN, send A5 00 01 00 07 07 -> core_reset_n drops on the sync byte; addr0=0x0007 is written; core_reset_n returns to 1.
6. Stop bit forced 0 on the second data byte -> ERROR, no imem_we for that word. Separately, assert reset_n_in mid-DATA_L -> all outputs 0, IDLE, next valid frame loads correctly.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART boot loader: sync byte, loader FSM states
// and the default UART bit-period computation.
package imem_uart_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_H  = 3'd1,
      ST_LEN_L  = 3'd2,
      ST_DATA_H = 3'd3,
      ST_DATA_L = 3'd4,
      ST_CHECK  = 3'd5,
      ST_RUN    = 3'd6,
      ST_ERROR  = 3'd7
   } loader_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/imem_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling with a down-counting
// bit timer, start-bit glitch rejection and stop-bit framing check.
module uart_rx_8n1
   import imem_uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset_n_in,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t        rx_state;
   logic [2:0]       sync_q;
   logic [CNT_W-1:0] timer;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             rx_s;
   logic             rx_fall;

   // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detect
   assign rx_s    = sync_q[1];
   assign rx_fall = sync_q[2] & ~sync_q[1];

   always_ff @(posedge clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[1:0], uart_rx};
      end
   end

   always_ff @(posedge clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         rx_state   <= RX_IDLE;
         timer      <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_fall) begin
                  timer    <= HALF_M1;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (timer == '0) begin
                  if (rx_s) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     timer    <= FULL_M1;
                     bit_idx  <= '0;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            RX_DATA: begin
               if (timer == '0) begin
                  shift <= {rx_s, shift[7:1]};
                  timer <= FULL_M1;
                  if (bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            RX_STOP: begin
               if (timer == '0) begin
                  byte_valid <= 1'b1;
                  rx_byte    <= shift;
                  frame_err  <= ~rx_s;
                  rx_state   <= RX_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a checksummed program image over UART, writes it into
// IMEM port A and holds the core in reset until a valid image is in place.
//
// state   | meaning
// IDLE    | after reset, waiting for sync byte
// LEN_H   | expecting length high byte
// LEN_L   | expecting length low byte, validates length
// DATA_H  | expecting high byte of next word
// DATA_L  | expecting low byte, issues the IMEM write
// CHECK   | expecting XOR checksum of data bytes
// RUN     | image valid, core released; sync byte restarts
// ERROR   | last load failed, core held; sync byte restarts
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int BAUD         = 115200,
   parameter int ADDR_W       = 10,
   parameter int MAX_WORDS    = 1024,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic              clk,
   input  logic              reset_n_in,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_din,
   output logic              core_reset_n,
   output logic              load_done,
   output logic              load_error
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   loader_state_t    state;
   logic             byte_valid;
   logic [7:0]       rx_byte;
   logic             frame_err;
   logic [7:0]       len_hi;
   logic [CNT_W-1:0] len;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_cnt_nxt;
   logic [7:0]       chk;
   logic [7:0]       data_hi;
   logic [15:0]      len_full;
   logic             byte_ok;
   logic             is_sync;
   logic             frame_abort;

   uart_rx_8n1 #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .reset_n_in (reset_n_in),
      .uart_rx    (uart_rx),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   always_comb begin
      len_full     = {len_hi, rx_byte};
      word_cnt_nxt = word_cnt + CNT_W'(1);
      byte_ok      = byte_valid & ~frame_err;
      is_sync      = byte_ok && (rx_byte == SYNC_BYTE);
      // a bad frame only matters while an image is in flight
      frame_abort  = byte_valid && frame_err &&
                     (state inside {ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CHECK});
   end

   always_ff @(posedge clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state        <= ST_IDLE;
         len_hi       <= '0;
         len          <= '0;
         word_cnt     <= '0;
         chk          <= '0;
         data_hi      <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_din     <= '0;
         core_reset_n <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (frame_abort) begin
            state        <= ST_ERROR;
            core_reset_n <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b1;
         end else begin
            case (state)
               ST_IDLE, ST_RUN, ST_ERROR: begin
                  if (is_sync) begin
                     core_reset_n <= 1'b0;
                     load_done    <= 1'b0;
                     state        <= ST_LEN_H;
                  end
               end
               ST_LEN_H: begin
                  if (byte_ok) begin
                     len_hi <= rx_byte;
                     state  <= ST_LEN_L;
                  end
               end
               ST_LEN_L: begin
                  if (byte_ok) begin
                     if (len_full == 16'd0 || len_full > MAX_LEN) begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                     end else begin
                        len      <= CNT_W'(len_full);
                        word_cnt <= '0;
                        chk      <= '0;
                        state    <= ST_DATA_H;
                     end
                  end
               end
               ST_DATA_H: begin
                  if (byte_ok) begin
                     data_hi <= rx_byte;
                     chk     <= chk ^ rx_byte;
                     state   <= ST_DATA_L;
                  end
               end
               ST_DATA_L: begin
                  if (byte_ok) begin
                     imem_we   <= 1'b1;
                     imem_addr <= word_cnt[ADDR_W-1:0];
                     imem_din  <= {data_hi, rx_byte};
                     chk       <= chk ^ rx_byte;
                     word_cnt  <= word_cnt_nxt;
                     state     <= (word_cnt_nxt == len) ? ST_CHECK : ST_DATA_H;
                  end
               end
               ST_CHECK: begin
                  if (byte_ok) begin
                     if (rx_byte == chk) begin
                        state        <= ST_RUN;
                        core_reset_n <= 1'b1;
                        load_done    <= 1'b1;
                        load_error   <= 1'b0;
                     end else begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: serial frames driven bit by bit, IMEM writes
// scoreboarded against a frame-level model, status checked after each frame.
module tb_imem_uart_loader;

   localparam int CPB       = 16;
   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 1024;

   logic              clk = 1'b0;
   logic              reset_n_in = 1'b0;
   logic              uart_rx = 1'b1;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_din;
   logic              core_reset_n;
   logic              load_done;
   logic              load_error;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [25:0] exp_q[$];
   logic [15:0] wq[$];
   logic        exp_core = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err  = 1'b0;

   always #5 clk = ~clk;

   imem_uart_loader #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .reset_n_in   (reset_n_in),
      .uart_rx      (uart_rx),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_din     (imem_din),
      .core_reset_n (core_reset_n),
      .load_done    (load_done),
      .load_error   (load_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // write monitor: every strobe must match the oldest expected write
   initial begin
      logic [25:0] e;
      forever begin
         @(negedge clk);
         if (reset_n_in && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h din 0x%0h, expected no write",
                        imem_addr, imem_din);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(imem_addr), 32'(e[25:16]));
               check("write_din", 32'(imem_din), 32'(e[15:0]));
            end
         end
      end
   end

   task automatic uart_send(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'(exp_core));
      check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
      check({tag, "_load_error"}, 32'(load_error), 32'(exp_err));
   endtask

   // Frame-level reference: sends A5, LEN, the words in wq and chk.
   // bad_idx >= 0 sends that data byte with a zero stop bit and stops there.
   task automatic send_frame(input logic [15:0] len, input logic [7:0] chk,
                             input int bad_idx, input bit glitch);
      logic [7:0] data[$];
      logic [7:0] x;
      bit         len_ok;
      bit         good;
      int         nwrites;
      len_ok = (len != 16'd0) && (32'(len) <= MAX_WORDS);
      data.delete();
      x = 8'h00;
      foreach (wq[i]) begin
         data.push_back(wq[i][15:8]);
         data.push_back(wq[i][7:0]);
         x = x ^ wq[i][15:8] ^ wq[i][7:0];
      end
      nwrites = !len_ok ? 0 : (bad_idx >= 0 ? bad_idx / 2 : int'(len));
      for (int i = 0; i < nwrites; i++) exp_q.push_back({10'(i), wq[i]});

      uart_send(8'hA5, 1'b1);
      exp_core = 1'b0;
      exp_done = 1'b0;
      check_status("after_sync");
      if (glitch) begin
         uart_rx = 1'b0;
         repeat (4) @(negedge clk);
         uart_rx = 1'b1;
         repeat (3 * CPB) @(negedge clk);
      end
      uart_send(len[15:8], 1'b1);
      uart_send(len[7:0], 1'b1);
      good = 1'b0;
      if (len_ok) begin
         if (bad_idx >= 0) begin
            for (int i = 0; i <= bad_idx; i++) uart_send(data[i], (i == bad_idx) ? 1'b0 : 1'b1);
         end else begin
            foreach (data[i]) uart_send(data[i], 1'b1);
            uart_send(chk, 1'b1);
            good = (chk == x);
         end
      end
      repeat (30) @(negedge clk);
      exp_core = good;
      exp_done = good;
      exp_err  = !good;
      check_status("frame_end");
      check("pending_writes", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] len;
      logic [7:0]  chk;
      repeat (3) @(negedge clk);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_din", 32'(imem_din), 32'd0);
      check_status("rst");
      reset_n_in = 1'b1;
      repeat (5) @(negedge clk);

      // good two-word image
      wq = '{16'h1234, 16'hABCD};
      send_frame(16'd2, 8'h40, -1, 1'b0);
      // bad checksum
      send_frame(16'd2, 8'h41, -1, 1'b0);
      // zero and oversized lengths
      wq.delete();
      send_frame(16'd0, 8'h00, -1, 1'b0);
      send_frame(16'h0401, 8'h00, -1, 1'b0);
      // garbage ignored in ERROR, then a glitch inside a good one-word frame
      uart_send(8'h00, 1'b1);
      uart_send(8'hFF, 1'b1);
      uart_send(8'h5A, 1'b1);
      repeat (10) @(negedge clk);
      check_status("garbage");
      wq = '{16'hBEEF};
      send_frame(16'd1, 8'hBE ^ 8'hEF, -1, 1'b1);
      // reload from RUN
      wq = '{16'h0007};
      send_frame(16'd1, 8'h07, -1, 1'b0);
      // framing error on second data byte
      wq = '{16'h1234, 16'hABCD};
      send_frame(16'd2, 8'h40, 1, 1'b0);
      // framing error on a later byte, after one word written
      wq = '{16'h1111, 16'h2222, 16'h3333};
      send_frame(16'd3, 8'h00, 3, 1'b0);

      // randomized images, some with corrupted checksum
      for (int r = 0; r < 6; r++) begin
         len = 16'($urandom_range(1, 6));
         wq.delete();
         chk = 8'h00;
         for (int i = 0; i < int'(len); i++) begin
            wq.push_back(16'($urandom));
            chk = chk ^ wq[i][15:8] ^ wq[i][7:0];
         end
         if ($urandom_range(0, 2) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
         send_frame(len, chk, -1, 1'b0);
      end

      // reset in the middle of DATA_L
      exp_q.push_back({10'd0, 16'h1234});
      uart_send(8'hA5, 1'b1);
      uart_send(8'h00, 1'b1);
      uart_send(8'h02, 1'b1);
      uart_send(8'h12, 1'b1);
      uart_send(8'h34, 1'b1);
      uart_send(8'hAB, 1'b1);
      uart_rx = 1'b0;
      repeat (5 * CPB) @(negedge clk);
      reset_n_in = 1'b0;
      #1;
      exp_core = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      check("midrst_imem_we", 32'(imem_we), 32'd0);
      check("midrst_imem_addr", 32'(imem_addr), 32'd0);
      check("midrst_imem_din", 32'(imem_din), 32'd0);
      check_status("midrst");
      uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      reset_n_in = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      check_status("post_rst");
      check("post_rst_pending", 32'(exp_q.size()), 32'd0);
      wq = '{16'h0A0B, 16'h0C0D};
      send_frame(16'd2, 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
